// File: rtl/booth_mul_pkg.sv
// Shared types for the booth_mul datapath: FSM states and the Booth
// recoding of the multiplier bit pair {Q[0], Q_1}.
package booth_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2
   } booth_op_t;

   // 01 ends a run of ones (add M), 10 starts one (subtract M).
   function automatic booth_op_t booth_decode(input logic [1:0] pair);
      booth_op_t op;
      case (pair)
         2'b01:   op = OP_ADD;
         2'b10:   op = OP_SUB;
         default: op = OP_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/booth_seq_mul_if.sv
// Operand/result bus of the sequential Booth multiplier.
// Handshakes: a transfer happens on a rising edge where valid && ready;
// the sender holds data stable and valid high until that edge, and ready
// never depends combinationally on valid.
interface booth_seq_mul_if #(parameter int N = 8);
   logic [N-1:0]   A;
   logic [N-1:0]   B;
   logic           in_valid;
   logic           in_ready;
   logic [2*N-1:0] P;
   logic           out_valid;
   logic           out_ready;
   logic           busy;

   modport master (
      output A, B, in_valid, out_ready,
      input  in_ready, P, out_valid, busy
   );

   modport slave (
      input  A, B, in_valid, out_ready,
      output in_ready, P, out_valid, busy
   );
endinterface

// File: rtl/booth_seq_mul_rca.sv
// Plain W-bit ripple-carry adder; the carry-out is not produced because
// the multiplier's accumulator is already wide enough to need none.
module booth_seq_mul_rca #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum
);

   logic carry;

   always_comb begin
      carry = cin;
      sum   = '0;
      for (int i = 0; i < W; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
      end
   end

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative signed radix-2 Booth multiplier: one shared N+1-bit adder,
// one iteration per cycle, N iterations per product.
module booth_seq_mul
   import booth_mul_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                CLK,
   input  logic                RST,
   booth_seq_mul_if.slave      bus,
   output state_t              state_dbg
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t          state;
   logic [N:0]      m;
   logic [N:0]      acc;
   logic [N-1:0]    q;
   logic            q_1;
   logic [CW-1:0]   cnt;
   logic [2*N-1:0]  p_reg;

   booth_op_t       op;
   logic [N:0]      add_b;
   logic            add_cin;
   logic [N:0]      add_sum;
   logic [N:0]      acc_next;
   logic [N:0]      acc_sh;
   logic [N-1:0]    q_sh;

   always_comb begin
      op       = booth_decode({q[0], q_1});
      add_b    = (op == OP_SUB) ? ~m : m;
      add_cin  = (op == OP_SUB);
      acc_next = (op == OP_NOP) ? acc : add_sum;
      // Arithmetic shift of {acc_next, q, q_1}; the sign bit is replicated.
      acc_sh   = {acc_next[N], acc_next[N:1]};
      q_sh     = {acc_next[0], q[N-1:1]};
   end

   booth_seq_mul_rca #(.W(N + 1)) u_rca (
      .a   (acc),
      .b   (add_b),
      .cin (add_cin),
      .sum (add_sum)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         m     <= '0;
         acc   <= '0;
         q     <= '0;
         q_1   <= 1'b0;
         cnt   <= '0;
         p_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  m     <= {bus.A[N-1], bus.A};
                  acc   <= '0;
                  q     <= bus.B;
                  q_1   <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc <= acc_sh;
               q   <= q_sh;
               q_1 <= q[0];
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  p_reg <= {acc_sh[N-1:0], q_sh};
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE) && !RST;
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.P         = p_reg;
   assign state_dbg     = state;

endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed bench for booth_seq_mul (N=8) with hand-computed products.
module tb_booth_seq_mul;
   import booth_mul_pkg::*;

   localparam int N = 8;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t state_dbg;
   int     n_checks = 0;
   int     n_fail   = 0;

   booth_seq_mul_if #(.N(N)) bus ();

   booth_seq_mul #(.N(N)) dut (
      .CLK       (clk),
      .RST       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits for in_ready, presents operands for one handshake edge, returns at t0+#1.
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
      int guard = 0;
      while (!bus.in_ready && guard < 50) begin
         step();
         guard++;
      end
      check("start_ready", 32'(bus.in_ready), 32'd1);
      bus.A        = a;
      bus.B        = b;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
   endtask

   // Counts edges until out_valid; compares against the expected edge count.
   task automatic wait_done(input string tag, input int exp_edges);
      int k = 0;
      while (!bus.out_valid && k < 40) begin
         step();
         k++;
      end
      check({tag, "_latency"}, 32'(k), 32'(exp_edges));
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] exp_p);
      start_op(a, b);
      wait_done(tag, N);
      check({tag, "_p"}, 32'(bus.P), 32'(exp_p));
      step();
      check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int bad;
      bus.A         = '0;
      bus.B         = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      step();
      step();
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_p", 32'(bus.P), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_release_ready", 32'(bus.in_ready), 32'd1);

      // Basic products with out_ready tied high
      start_op(8'd3, 8'd5);
      check("run_busy", 32'(bus.busy), 32'd1);
      check("run_in_ready", 32'(bus.in_ready), 32'd0);
      check("run_state", 32'(state_dbg), 32'(RUN));
      wait_done("mul_3x5", N);
      check("mul_3x5_p", 32'(bus.P), 32'h000F);
      step();
      check("mul_3x5_ready_after", 32'(bus.in_ready), 32'd1);

      run_op("mul_m7x6", 8'hF9, 8'd6, 16'hFFD6);
      run_op("mul_6xm7", 8'd6, 8'hF9, 16'hFFD6);
      run_op("mul_m128xm128", 8'h80, 8'h80, 16'h4000);
      run_op("mul_0xm1", 8'd0, 8'hFF, 16'h0000);

      // Back-pressure: result held for five cycles, accepted on the sixth
      bus.out_ready = 1'b0;
      start_op(8'd127, 8'h80);
      wait_done("bp", N);
      for (int i = 0; i < 5; i++) begin
         check("bp_p", 32'(bus.P), 32'hC080);
         check("bp_valid", 32'(bus.out_valid), 32'd1);
         check("bp_in_ready", 32'(bus.in_ready), 32'd0);
         if (i < 4) step();
      end
      check("bp_state", 32'(state_dbg), 32'(DONE));
      step();
      bus.out_ready = 1'b1;
      step();
      check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
      check("bp_idle_valid", 32'(bus.out_valid), 32'd0);

      // in_valid pulsed during RUN must be ignored
      start_op(8'd3, 8'd5);
      bus.A        = 8'd9;
      bus.B        = 8'd9;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      wait_done("ignore", N - 1);
      check("ignore_p", 32'(bus.P), 32'h000F);
      step();
      do_reset();
      run_op("post_rst_5xm3", 8'd5, 8'hFD, 16'hFFF1);

      // Reset at iteration 3 aborts the product
      start_op(8'd7, 8'd7);
      step();
      step();
      rst = 1'b1;
      #1;
      check("abort_ready_in_rst", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_ready", 32'(bus.in_ready), 32'd1);
      check("abort_p", 32'(bus.P), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      bad = 0;
      for (int i = 0; i < N + 4; i++) begin
         if (bus.out_valid) bad++;
         step();
      end
      check("abort_no_valid", 32'(bad), 32'd0);
      run_op("mul_2x2", 8'd2, 8'd2, 16'h0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
